ahblite_arbiter_4m: RTL and testbench
=====================================

AHBLITE_ARBITER_4M -- requirements
Module: ahblite_arbiter_4m

Interface
REQ-001 SHALL have port hclk_i, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port hrst_i, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port req_i, input, 4, bus request per master (bit n = master n).
REQ-004 SHALL have port lock_i, input, 4, locked-transfer request per master.
REQ-005 SHALL have port htrans_i, input, 2, HTRANS of current address-phase owner (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
REQ-006 SHALL have port hburst_i, input, 3, HBURST of current address-phase owner.
REQ-007 SHALL have port hready_i, input, 1, bus HREADY; high = current transfers accepted.
REQ-008 SHALL have port gnt_o, output, 4, one-hot grant, owner of next address phase.
REQ-009 SHALL have port master_o, output, 2, encoded index of gnt_o.
REQ-010 SHALL have port master_dp_o, output, 2, encoded index of data-phase owner, for the data/response mux.

Function
REQ-011 SHALL keep gnt_o exactly one-hot at all times; master_o SHALL always equal the index of gnt_o.
REQ-012 SHALL keep a 4-bit beat counter cnt; state changes only on edges with hready_i=1.
REQ-013 SHALL, on accepted NONSEQ, load cnt = beats-1: SINGLE 0, INCR4/WRAP4 3, INCR8/WRAP8 7, INCR16/WRAP16 15, INCR 15 (cap).
REQ-014 SHALL, on accepted SEQ with cnt>0, decrement cnt; on accepted IDLE, clear cnt; on accepted BUSY, hold cnt.
REQ-015 SHALL define arbitration point = hready_i=1 AND htrans_i!=BUSY AND next-cnt==0; additionally for hburst_i=INCR, any hready_i=1 edge with htrans_i!=BUSY where req_i[owner]=0.
REQ-016 SHALL, at an arbitration point, select the next owner round-robin: first requesting master searching master_o+1, +2, +3, +0 modulo 4.
REQ-017 SHALL, at an arbitration point with req_i==0, grant master 0 (default master).
REQ-018 SHALL hold gnt_o unchanged on every edge that is not an arbitration point, including all hready_i=0 cycles.
REQ-019 SHALL update gnt_o/master_o registered, one cycle after the arbitration-point edge, with no combinational path from inputs to outputs.
REQ-020 SHALL load master_dp_o <= master_o on every edge with hready_i=1; hold otherwise.
REQ-021 SHALL, when the current owner is the only requester at an arbitration point, re-grant it (no idle gap).

Reset
REQ-022 SHALL, with hrst_i=1 at an edge: gnt_o=4'b0001, master_o=0, master_dp_o=0, cnt=0, lock state cleared.
REQ-023 SHALL give reset priority over all other events, including mid-burst and hready_i=0.
REQ-024 SHALL make the first arbitration after reset search starting from master 1.

Configuration
REQ-025 SHALL implement locked transfers only when macro AHBLITE_ARB_LOCK_EN is defined.
REQ-026 SHALL, with AHBLITE_ARB_LOCK_EN defined, suppress rearbitration while lock_i[master_o]=1 at the would-be arbitration point; grant is held until an arbitration point with lock_i[master_o]=0.
REQ-027 SHALL, without AHBLITE_ARB_LOCK_EN, ignore lock_i entirely; port remains present.

Verification
REQ-028 SHALL cover: reset, req_i=0 -> gnt_o=0001, master_o=0, master_dp_o=0, held indefinitely.
REQ-029 SHALL cover: req_i=1111, all SINGLE NONSEQ, hready_i=1 -> grant rotates 0,1,2,3,0 one per transfer.
REQ-030 SHALL cover: master 2 INCR4 with req_i=0110, hready_i=0 on beat 2 for 3 cycles -> gnt_o=0100 held through all 4 beats, then master 1; master_dp_o lags master_o by one accepted beat.
REQ-031 SHALL cover: master 3 INCR, drops req_i after 5 beats while master 0 requests -> gnt_o=0001 one cycle after that edge; with req held, release after 16 beats.
REQ-032 SHALL cover: lock_i=0010 with master 1 issuing SINGLEs, req_i=1111 -> with AHBLITE_ARB_LOCK_EN grant stays 0010 until lock drops; without, rotation per REQ-029.
REQ-033 SHALL cover: hrst_i=1 mid-WRAP8 of master 2 -> next cycle gnt_o=0001, cnt=0, master_dp_o=0.

Source files
------------

// File: rtl/ahblite_arbiter_4m.sv
// rtl/ahblite_arbiter_4m.sv - Four-master AHB-Lite round-robin arbiter with burst-aware rearbitration.
// Optional locked transfers are enabled by defining AHBLITE_ARB_LOCK_EN.
module ahblite_arbiter_4m (
    input  logic       hclk_i,
    input  logic       hrst_i,
    input  logic [3:0] req_i,
    input  logic [3:0] lock_i,
    input  logic [1:0] htrans_i,
    input  logic [2:0] hburst_i,
    input  logic       hready_i,
    output logic [3:0] gnt_o,
    output logic [1:0] master_o,
    output logic [1:0] master_dp_o
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR   = 3'b001;
    localparam logic [2:0] BURST_WRAP4  = 3'b010;
    localparam logic [2:0] BURST_INCR4  = 3'b011;
    localparam logic [2:0] BURST_WRAP8  = 3'b100;
    localparam logic [2:0] BURST_INCR8  = 3'b101;

    logic [3:0] r_gnt;
    logic [1:0] r_master;
    logic [1:0] r_master_dp;
    logic [3:0] r_cnt;

    logic [3:0] w_burst_len;
    logic [3:0] w_cnt_nxt;
    logic       w_arb_raw;
    logic       w_arb;
    logic [1:0] w_next_master;
    logic       w_found;
    logic [1:0] w_idx;

    // Remaining beats after the NONSEQ; undefined-length INCR is capped at 16 beats.
    always_comb begin
        w_burst_len = 4'd15;
        case (hburst_i)
            BURST_SINGLE:             w_burst_len = 4'd0;
            BURST_INCR:               w_burst_len = 4'd15;
            BURST_WRAP4, BURST_INCR4: w_burst_len = 4'd3;
            BURST_WRAP8, BURST_INCR8: w_burst_len = 4'd7;
            default:                  w_burst_len = 4'd15;
        endcase
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (hready_i) begin
            case (htrans_i)
                TRANS_IDLE:   w_cnt_nxt = 4'd0;
                TRANS_BUSY:   w_cnt_nxt = r_cnt;
                TRANS_NONSEQ: w_cnt_nxt = w_burst_len;
                TRANS_SEQ:    w_cnt_nxt = (r_cnt != 4'd0) ? r_cnt - 4'd1 : 4'd0;
                default:      w_cnt_nxt = r_cnt;
            endcase
        end
    end

    // An INCR owner that stops requesting gives the bus up before its beat cap.
    assign w_arb_raw = hready_i && (htrans_i != TRANS_BUSY) &&
                       ((w_cnt_nxt == 4'd0) ||
                        ((hburst_i == BURST_INCR) && !req_i[r_master]));

`ifdef AHBLITE_ARB_LOCK_EN
    assign w_arb = w_arb_raw && !lock_i[r_master];
`else
    logic w_unused_lock;
    assign w_unused_lock = ^lock_i;
    assign w_arb         = w_arb_raw;
`endif

    // Search starts one past the current owner and wraps back to it last.
    always_comb begin
        w_next_master = 2'd0;
        w_found       = 1'b0;
        w_idx         = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_master + 2'(i);
            if (!w_found && req_i[w_idx]) begin
                w_next_master = w_idx;
                w_found       = 1'b1;
            end
        end
    end

    always_ff @(posedge hclk_i) begin
        if (hrst_i) begin
            r_gnt       <= 4'b0001;
            r_master    <= 2'd0;
            r_master_dp <= 2'd0;
            r_cnt       <= 4'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_arb) begin
                r_master <= w_next_master;
                r_gnt    <= 4'b0001 << w_next_master;
            end
            if (hready_i) begin
                r_master_dp <= r_master;
            end
        end
    end

    assign gnt_o       = r_gnt;
    assign master_o    = r_master;
    assign master_dp_o = r_master_dp;

endmodule

// File: tb/tb_ahblite_arbiter_4m.sv
// tb/tb_ahblite_arbiter_4m.sv - Directed self-checking bench for ahblite_arbiter_4m.
module tb_ahblite_arbiter_4m;

    logic       hclk_i = 1'b0;
    logic       hrst_i;
    logic [3:0] req_i;
    logic [3:0] lock_i;
    logic [1:0] htrans_i;
    logic [2:0] hburst_i;
    logic       hready_i;
    logic [3:0] gnt_o;
    logic [1:0] master_o;
    logic [1:0] master_dp_o;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000, INCR = 3'b001, INCR4 = 3'b011, WRAP8 = 3'b100;

    ahblite_arbiter_4m dut (
        .hclk_i      (hclk_i),
        .hrst_i      (hrst_i),
        .req_i       (req_i),
        .lock_i      (lock_i),
        .htrans_i    (htrans_i),
        .hburst_i    (hburst_i),
        .hready_i    (hready_i),
        .gnt_o       (gnt_o),
        .master_o    (master_o),
        .master_dp_o (master_dp_o)
    );

    always #5 hclk_i = ~hclk_i;

    task automatic cyc();
        @(posedge hclk_i);
        #1;
    endtask

    task automatic do_reset();
        hrst_i   = 1'b1;
        req_i    = 4'b0000;
        lock_i   = 4'b0000;
        htrans_i = IDLE;
        hburst_i = SINGLE;
        hready_i = 1'b1;
        cyc();
        hrst_i = 1'b0;
    endtask

    // Park the bus on master m using an IDLE arbitration cycle from reset state.
    task automatic grab(input logic [1:0] m);
        req_i    = 4'b0001 << m;
        htrans_i = IDLE;
        hburst_i = SINGLE;
        hready_i = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        hrst_i   = 1'b1;
        req_i    = 4'b1111;
        lock_i   = 4'b0000;
        htrans_i = NONSEQ;
        hburst_i = INCR4;
        hready_i = 1'b0;
        cyc();
        n_total++;
        if (gnt_o !== 4'b0001) $display("FAIL reset_gnt got %b want 0001", gnt_o);
        else n_pass++;
        n_total++;
        if (master_o !== 2'd0 || master_dp_o !== 2'd0)
            $display("FAIL reset_master got %0d/%0d want 0/0", master_o, master_dp_o);
        else n_pass++;
        hrst_i = 1'b0;
    endtask

    task automatic test_idle_default();
        do_reset();
        req_i    = 4'b0000;
        htrans_i = IDLE;
        hready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            n_total++;
            if (gnt_o !== 4'b0001 || master_o !== 2'd0 || master_dp_o !== 2'd0)
                $display("FAIL idle_default[%0d] got %b/%0d/%0d want 0001/0/0", k, gnt_o, master_o, master_dp_o);
            else n_pass++;
        end
    endtask

    task automatic test_rotation();
        logic [1:0] exp_m;
        logic [1:0] exp_dp;
        do_reset();
        req_i    = 4'b1111;
        htrans_i = NONSEQ;
        hburst_i = SINGLE;
        hready_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            exp_m  = 2'(k);
            exp_dp = 2'(k - 1);
            n_total++;
            if (master_o !== exp_m || gnt_o !== (4'b0001 << exp_m))
                $display("FAIL rotation[%0d] got %b/%0d want master %0d", k, gnt_o, master_o, exp_m);
            else n_pass++;
            n_total++;
            if (master_dp_o !== exp_dp)
                $display("FAIL rotation_dp[%0d] got %0d want %0d", k, master_dp_o, exp_dp);
            else n_pass++;
        end
    endtask

    task automatic test_burst_wait();
        do_reset();
        grab(2'd2);
        n_total++;
        if (gnt_o !== 4'b0100) $display("FAIL burst_grab got %b want 0100", gnt_o);
        else n_pass++;
        req_i    = 4'b0110;
        htrans_i = NONSEQ;
        hburst_i = INCR4;
        cyc();
        n_total++;
        if (gnt_o !== 4'b0100 || master_dp_o !== 2'd2)
            $display("FAIL burst_beat1 got %b dp %0d want 0100 dp 2", gnt_o, master_dp_o);
        else n_pass++;
        htrans_i = SEQ;
        cyc();
        hready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_total++;
            if (gnt_o !== 4'b0100) $display("FAIL burst_wait[%0d] got %b want 0100", k, gnt_o);
            else n_pass++;
        end
        hready_i = 1'b1;
        cyc();
        n_total++;
        if (gnt_o !== 4'b0100) $display("FAIL burst_beat3 got %b want 0100", gnt_o);
        else n_pass++;
        cyc();
        n_total++;
        if (gnt_o !== 4'b0010 || master_o !== 2'd1 || master_dp_o !== 2'd2)
            $display("FAIL burst_handover got %b/%0d dp %0d want 0010/1 dp 2", gnt_o, master_o, master_dp_o);
        else n_pass++;
        req_i    = 4'b0010;
        htrans_i = IDLE;
        cyc();
        n_total++;
        if (gnt_o !== 4'b0010 || master_dp_o !== 2'd1)
            $display("FAIL burst_regrant got %b dp %0d want 0010 dp 1", gnt_o, master_dp_o);
        else n_pass++;
    endtask

    task automatic test_incr_release();
        do_reset();
        grab(2'd3);
        req_i    = 4'b1001;
        htrans_i = NONSEQ;
        hburst_i = INCR;
        cyc();
        htrans_i = SEQ;
        for (int k = 0; k < 4; k++) cyc();
        n_total++;
        if (gnt_o !== 4'b1000) $display("FAIL incr_5beats got %b want 1000", gnt_o);
        else n_pass++;
        req_i = 4'b0001;
        cyc();
        n_total++;
        if (gnt_o !== 4'b0001 || master_o !== 2'd0)
            $display("FAIL incr_drop got %b/%0d want 0001/0", gnt_o, master_o);
        else n_pass++;

        do_reset();
        grab(2'd3);
        req_i    = 4'b1001;
        htrans_i = NONSEQ;
        hburst_i = INCR;
        cyc();
        htrans_i = SEQ;
        for (int k = 0; k < 14; k++) cyc();
        n_total++;
        if (gnt_o !== 4'b1000) $display("FAIL incr_15beats got %b want 1000", gnt_o);
        else n_pass++;
        cyc();
        n_total++;
        if (gnt_o !== 4'b0001) $display("FAIL incr_cap16 got %b want 0001", gnt_o);
        else n_pass++;
    endtask

    task automatic test_lock();
        logic [1:0] exp_m [4];
`ifdef AHBLITE_ARB_LOCK_EN
        exp_m[0] = 2'd1; exp_m[1] = 2'd1; exp_m[2] = 2'd1; exp_m[3] = 2'd2;
`else
        exp_m[0] = 2'd2; exp_m[1] = 2'd3; exp_m[2] = 2'd0; exp_m[3] = 2'd1;
`endif
        do_reset();
        grab(2'd1);
        req_i    = 4'b1111;
        lock_i   = 4'b0010;
        htrans_i = NONSEQ;
        hburst_i = SINGLE;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) lock_i = 4'b0000;
            cyc();
            n_total++;
            if (master_o !== exp_m[k] || gnt_o !== (4'b0001 << exp_m[k]))
                $display("FAIL lock[%0d] got %b/%0d want master %0d", k, gnt_o, master_o, exp_m[k]);
            else n_pass++;
        end
        lock_i = 4'b0000;
    endtask

    task automatic test_reset_midburst();
        do_reset();
        grab(2'd2);
        htrans_i = NONSEQ;
        hburst_i = WRAP8;
        cyc();
        htrans_i = SEQ;
        cyc();
        cyc();
        hrst_i   = 1'b1;
        hready_i = 1'b0;
        cyc();
        n_total++;
        if (gnt_o !== 4'b0001 || master_o !== 2'd0 || master_dp_o !== 2'd0)
            $display("FAIL midburst_reset got %b/%0d/%0d want 0001/0/0", gnt_o, master_o, master_dp_o);
        else n_pass++;
        // A cleared counter makes the very next SEQ edge an arbitration point.
        hrst_i   = 1'b0;
        hready_i = 1'b1;
        cyc();
        n_total++;
        if (gnt_o !== 4'b0100) $display("FAIL midburst_cnt_clear got %b want 0100", gnt_o);
        else n_pass++;
    endtask

    initial begin
        hrst_i   = 1'b1;
        req_i    = 4'b0000;
        lock_i   = 4'b0000;
        htrans_i = IDLE;
        hburst_i = SINGLE;
        hready_i = 1'b0;
        test_reset();
        test_idle_default();
        test_rotation();
        test_burst_wait();
        test_incr_release();
        test_lock();
        test_reset_midburst();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
